// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, bit shifting
// on filtered device clock falling edges, odd parity, stop, ACK check and timeout.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned SETUP_CYCLES   = 25,
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned FILTER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int unsigned PW = $clog2(PHASE_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t          state;
    logic [1:0]      clk_sync;
    logic [1:0]      data_sync;
    logic            clk_s;
    logic            data_s;
    logic            clk_filt;
    logic [FW-1:0]   filt_cnt;
    logic            fall_c;
    logic [PW-1:0]   phase_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [3:0]      bit_cnt;
    logic [8:0]      shreg;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // A filtered falling edge is the cycle the accepted clock level goes 1 -> 0.
    assign fall_c = clk_filt & ~clk_s & (filt_cnt == FW'(FILTER_CYCLES - 1));

    // Two-flop synchronizers for the asynchronous bus pins (idle bus is high).
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    // Clock deglitcher: level changes only after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_CYCLES - 1)) begin
            clk_filt <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    // Transfer FSM with registered bus enables and handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            phase_cnt   <= '0;
            tmo_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        shreg      <= {~^tx_data, tx_data};
                        state      <= S_INHIBIT;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        phase_cnt  <= '0;
                    end
                end
                S_INHIBIT: begin
                    if (phase_cnt == PW'(INHIBIT_CYCLES - 1)) begin
                        phase_cnt   <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= S_RTS;
                    end else begin
                        phase_cnt <= phase_cnt + PW'(1);
                    end
                end
                S_RTS: begin
                    if (phase_cnt == PW'(SETUP_CYCLES - 1)) begin
                        phase_cnt  <= '0;
                        ps2_clk_oe <= 1'b0;
                        tmo_cnt    <= '0;
                        bit_cnt    <= '0;
                        state      <= S_SHIFT;
                    end else begin
                        phase_cnt <= phase_cnt + PW'(1);
                    end
                end
                S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        error       <= 1'b1;
                        state       <= S_IDLE;
                        tx_ready    <= 1'b1;
                        busy        <= 1'b0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tmo_cnt     <= '0;
                        bit_cnt     <= '0;
                    end else if (state == S_SHIFT) begin
                        // Data bits LSB first, then parity, then a released (high) stop bit.
                        if (fall_c) begin
                            ps2_data_oe <= ~shreg[0];
                            shreg       <= {1'b1, shreg[8:1]};
                            bit_cnt     <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd9) begin
                                state <= S_ACK;
                            end
                        end
                    end else if (state == S_ACK) begin
                        if (fall_c) begin
                            if (!data_s) begin
                                state <= S_WAIT_IDLE;
                            end else begin
                                error       <= 1'b1;
                                state       <= S_IDLE;
                                tx_ready    <= 1'b1;
                                busy        <= 1'b0;
                                ps2_clk_oe  <= 1'b0;
                                ps2_data_oe <= 1'b0;
                                tmo_cnt     <= '0;
                                bit_cnt     <= '0;
                            end
                        end
                    end else begin
                        if (clk_filt && data_s) begin
                            done        <= 1'b1;
                            state       <= S_IDLE;
                            tx_ready    <= 1'b1;
                            busy        <= 1'b0;
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b0;
                            tmo_cnt     <= '0;
                            bit_cnt     <= '0;
                        end
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    tx_ready    <= 1'b1;
                    busy        <= 1'b0;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 20;
    localparam int unsigned SET  = 5;
    localparam int unsigned TMO  = 3000;
    localparam int unsigned FLT  = 8;
    localparam int unsigned HALF = 40;
    localparam int BOUND = 20000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, error;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       is_err;
        logic       chk_frame;
        logic [9:0] frame;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] cap_frame = '0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SET),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_CYCLES (FLT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Open-drain bus: either side pulling low wins.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic push(input logic is_err, input logic chk, input logic [9:0] f);
        exp_t e;
        e.is_err    = is_err;
        e.chk_frame = chk;
        e.frame     = f;
        exp_q.push_back(e);
    endtask

    // Monitor: every done/error pulse consumes one expected outcome.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (done || error)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse done=%0b error=%0b", done, error);
            end else begin
                e = exp_q.pop_front();
                check("pulse_error", 32'(error), 32'(e.is_err));
                check("pulse_done", 32'(done), 32'(!e.is_err));
                check("oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
                if (e.chk_frame) check("frame", 32'(cap_frame), 32'(e.frame));
            end
        end
    end

    // Issue one byte from idle; optionally check the inhibit and setup timing.
    task automatic start_tx(input logic [7:0] d, input bit timing);
        int cnt;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        if (timing) begin
            check("accept_outputs", 32'({tx_ready, busy, ps2_clk_oe, ps2_data_oe}), 32'b0110);
        end
        cnt = 0;
        while (!ps2_data_oe && cnt < BOUND) begin
            @(negedge clk);
            cnt++;
        end
        if (timing) check("inhibit_len", 32'(cnt), 32'(INH));
        else        check("rts_reached", 32'(cnt < BOUND), 32'd1);
        cnt = 0;
        while (ps2_clk_oe && cnt < BOUND) begin
            @(negedge clk);
            cnt++;
        end
        if (timing) check("setup_len", 32'(cnt), 32'(SET));
        else        check("clk_released", 32'(cnt < BOUND), 32'd1);
    endtask

    // Device model: clocks the frame, samples on rising edges, optionally ACKs.
    task automatic bfm_frame(input int abort_at, input bit ack, input bit glitch);
        int cnt = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && cnt < BOUND) begin
            @(negedge clk);
            cnt++;
        end
        check("bfm_rts_seen", 32'(cnt < BOUND), 32'd1);
        repeat (HALF) @(negedge clk);
        cap_frame = '0;
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (k == abort_at) return;
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
            cap_frame[k-1] = ps2_data_in;
            if (glitch && (k == 3 || k == 7)) begin
                dev_clk_low = 1'b1;
                repeat (4) @(negedge clk);
                dev_clk_low = 1'b0;
            end
            repeat (HALF / 2) @(negedge clk);
        end
        if (ack) dev_data_low = 1'b1;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (10) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (!(tx_ready && !busy) && cnt < BOUND) begin
            @(negedge clk);
            cnt++;
        end
        check("idle_reached", 32'(cnt < BOUND), 32'd1);
    endtask

    logic [7:0] par_byte [4] = '{8'h00, 8'h01, 8'hFF, 8'h80};
    logic [9:0] par_frame[4] = '{10'h300, 10'h201, 10'h3FF, 10'h280};

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({tx_ready, busy, done, error, ps2_clk_oe, ps2_data_oe}), 32'b100000);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 0xED with timing checks and ACK
        push(1'b0, 1'b1, 10'h3ED);
        start_tx(8'hED, 1'b1);
        bfm_frame(0, 1'b1, 1'b0);
        wait_idle();
        @(negedge clk);
        check("after_done", 32'({tx_ready, busy, done}), 32'b100);

        // parity coverage
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 1'b1, par_frame[i]);
            start_tx(par_byte[i], 1'b0);
            bfm_frame(0, 1'b1, 1'b0);
            wait_idle();
        end

        // no ACK on the 11th edge
        push(1'b1, 1'b1, 10'h33C);
        start_tx(8'h3C, 1'b0);
        bfm_frame(0, 1'b0, 1'b0);
        wait_idle();

        // device never clocks: timeout, with an ignored tx_valid meanwhile
        push(1'b1, 1'b0, 10'h000);
        start_tx(8'h55, 1'b0);
        cnt = 0;
        while (!error && cnt < int'(TMO) + 100) begin
            @(negedge clk);
            cnt++;
            if (cnt == 100) begin
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
            end
            if (cnt == 105) tx_valid = 1'b0;
        end
        check("timeout_len", 32'(cnt), 32'(TMO));
        repeat (5) @(negedge clk);
        check("after_timeout", 32'({tx_ready, busy, ps2_clk_oe, ps2_data_oe}), 32'b1000);

        // reset at bit 5, then a normal 0xFF transfer
        start_tx(8'hA5, 1'b0);
        bfm_frame(5, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("reset_mid_hs", 32'({tx_ready, busy, done, error}), 32'b1000);
        dev_clk_low = 1'b0;
        reset = 1'b0;
        repeat (50) @(negedge clk);
        push(1'b0, 1'b1, 10'h3FF);
        start_tx(8'hFF, 1'b0);
        bfm_frame(0, 1'b1, 1'b0);
        wait_idle();

        // clock glitches mid-frame
        push(1'b0, 1'b1, 10'h3ED);
        start_tx(8'hED, 1'b0);
        bfm_frame(0, 1'b1, 1'b1);
        wait_idle();

        // back-to-back with tx_valid held
        push(1'b0, 1'b1, 10'h3ED);
        push(1'b0, 1'b1, 10'h201);
        @(negedge clk);
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data  = 8'h01;
        bfm_frame(0, 1'b1, 1'b0);
        cnt = 0;
        while (!tx_ready && cnt < BOUND) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_ready", 32'(cnt < BOUND), 32'd1);
        @(negedge clk);
        check("b2b_accept", 32'({busy, ps2_clk_oe}), 32'b11);
        tx_valid = 1'b0;
        bfm_frame(0, 1'b1, 1'b0);
        wait_idle();

        repeat (20) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
